// File: rtl/i2c_arb_pkg.sv
// Shared state encoding, default widths and sizing helper for the I2C request arbiter.
package i2c_arb_pkg;

  localparam int unsigned DefAddrW = 7;
  localparam int unsigned DefRegW  = 8;
  localparam int unsigned DefDataW = 8;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StGrant    = 3'd1;
  localparam logic [2:0] StLaunch   = 3'd2;
  localparam logic [2:0] StWait     = 3'd3;
  localparam logic [2:0] StComplete = 3'd4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Client request bundle plus the control bundle towards the shared I2C master engine.
interface i2c_req_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = i2c_arb_pkg::DefAddrW,
  parameter int unsigned REG_W   = i2c_arb_pkg::DefRegW,
  parameter int unsigned DATA_W  = i2c_arb_pkg::DefDataW
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_slave_addr;
  logic [NUM_REQ*REG_W-1:0]  req_reg_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic                      err;
  logic [DATA_W-1:0]         rd_data;
  logic                      m_enable;
  logic [ADDR_W-1:0]         m_slave_addr;
  logic [REG_W-1:0]          m_reg_addr;
  logic [DATA_W-1:0]         m_data_in;
  logic                      m_read_write;
  logic                      m_done;
  logic                      m_nack;
  logic [DATA_W-1:0]         m_rd_data;

  modport master (
    input  req, req_slave_addr, req_reg_addr, req_wdata, req_rw,
    input  m_done, m_nack, m_rd_data,
    output gnt, done, err, rd_data,
    output m_enable, m_slave_addr, m_reg_addr, m_data_in, m_read_write
  );

  modport slave (
    output req, req_slave_addr, req_reg_addr, req_wdata, req_rw,
    output m_done, m_nack, m_rd_data,
    input  gnt, done, err, rd_data,
    input  m_enable, m_slave_addr, m_reg_addr, m_data_in, m_read_write
  );

endinterface

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin pick: first set request after last_gnt_i, wrapping.
module i2c_rr_pick import i2c_arb_pkg::*; #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    last_gnt_i,
  output logic [NUM_REQ-1:0] winner_o,
  output logic [IdxW-1:0]    idx_o
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    found    = 1'b0;
    cand     = '0;
    winner_o = '0;
    idx_o    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(last_gnt_i) + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        winner_o[cand] = 1'b1;
        idx_o          = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin sharing of one register-addressed I2C master among NUM_REQ clients,
// with a saturating watchdog that aborts transactions the master never finishes.
module i2c_req_arbiter import i2c_arb_pkg::*; #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned REG_W   = DefRegW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned TIMEOUT = 4096
) (
  input logic               clk_i,
  input logic               rst_ni,
  i2c_req_arbiter_if.master bus
);

  localparam int unsigned     IdxW    = clog2(NUM_REQ);
  localparam int unsigned     CntW    = clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [2:0]         state_q, state_d;
  logic [IdxW-1:0]    last_q, last_d, win_q, win_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic               err_q, err_d, en_q, en_d, rw_q, rw_d;
  logic [DATA_W-1:0]  rd_q, rd_d, wd_q, wd_d;
  logic [ADDR_W-1:0]  sa_q, sa_d;
  logic [REG_W-1:0]   ra_q, ra_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IdxW-1:0]    pick_idx;

  i2c_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i      (bus.req),
    .last_gnt_i (last_q),
    .winner_o   (pick_onehot),
    .idx_o      (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = err_q;
    rd_d    = rd_q;
    en_d    = en_q;
    sa_d    = sa_q;
    ra_d    = ra_q;
    wd_d    = wd_q;
    rw_d    = rw_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          win_d   = pick_idx;
          last_d  = pick_idx;
          gnt_d   = pick_onehot;
          state_d = StGrant;
        end
      end
      StGrant: begin
        // Last cycle the client's command is looked at.
        sa_d    = bus.req_slave_addr[int'(win_q)*ADDR_W +: ADDR_W];
        ra_d    = bus.req_reg_addr[int'(win_q)*REG_W +: REG_W];
        wd_d    = bus.req_wdata[int'(win_q)*DATA_W +: DATA_W];
        rw_d    = bus.req_rw[win_q];
        en_d    = 1'b1;
        state_d = StLaunch;
      end
      StLaunch: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (bus.m_done) begin
          err_d   = bus.m_nack;
          if (rw_q) rd_d = bus.m_rd_data;
          en_d    = 1'b0;
          state_d = StComplete;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          en_d    = 1'b0;
          state_d = StComplete;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StComplete: begin
        done_d  = gnt_q;
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      last_q  <= IdxW'(NUM_REQ - 1);
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rd_q    <= '0;
      en_q    <= 1'b0;
      sa_q    <= '0;
      ra_q    <= '0;
      wd_q    <= '0;
      rw_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      en_q    <= en_d;
      sa_q    <= sa_d;
      ra_q    <= ra_d;
      wd_q    <= wd_d;
      rw_q    <= rw_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.rd_data      = rd_q;
  assign bus.m_enable     = en_q;
  assign bus.m_slave_addr = sa_q;
  assign bus.m_reg_addr   = ra_q;
  assign bus.m_data_in    = wd_q;
  assign bus.m_read_write = rw_q;

endmodule
